// File: rtl/logic_op_bist.sv
// rtl/logic_op_bist.sv - BIST sweep engine for the ALU XOR/AND/OR logic units
// Drives every (i, j) operand pair onto the unit, checks its result and logs mismatches.
module logic_op_bist #(
  parameter int WIDTH   = 32,
  parameter int OP_BITS = 8,
  parameter int ERR_W   = 2*OP_BITS+1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op_sel,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic [WIDTH-1:0]   dut_x,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               bad_op,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [OP_BITS-1:0] fail_a,
  output logic [OP_BITS-1:0] fail_b
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam logic [OP_BITS-1:0] OP_ONE  = OP_BITS'(1);
  localparam logic [ERR_W-1:0]   ERR_ONE = ERR_W'(1);
  localparam int                 PAD     = WIDTH - OP_BITS;

  logic [1:0]         state;
  logic [1:0]         opReg;
  logic [OP_BITS-1:0] i;
  logic [OP_BITS-1:0] j;
  logic [OP_BITS-1:0] nextI;
  logic [OP_BITS-1:0] nextJ;
  logic [WIDTH-1:0]   expected;
  logic               mismatch;
  logic               lastPair;
  logic [ERR_W-1:0]   errNext;

  always_comb begin
    expected = '0;
    case (opReg)
      OP_XOR:  expected = dut_a ^ dut_b;
      OP_AND:  expected = dut_a & dut_b;
      OP_OR:   expected = dut_a | dut_b;
      default: expected = '0;
    endcase
  end

  // j is the inner loop; i advances only when j wraps.
  always_comb begin
    nextJ    = j + OP_ONE;
    nextI    = (&j) ? (i + OP_ONE) : i;
    lastPair = (&i) && (&j);
    mismatch = (dut_x != expected);
    errNext  = err_count;
    if (mismatch && !(&err_count)) errNext = err_count + ERR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      opReg      <= OP_XOR;
      i          <= '0;
      j          <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      pass       <= 1'b0;
      bad_op     <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opReg      <= op_sel;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            pass       <= 1'b0;
            i          <= '0;
            j          <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            if (op_sel == OP_BAD) begin
              bad_op <= 1'b1;
              state  <= DONE;
            end else begin
              bad_op <= 1'b0;
              state  <= DRIVE;
            end
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          err_count <= errNext;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= i;
            fail_b     <= j;
          end
          i <= nextI;
          j <= nextJ;
          if (lastPair) begin
            state <= DONE;
            dut_a <= '0;
            dut_b <= '0;
            pass  <= (errNext == '0);
          end else begin
            state <= DRIVE;
            dut_a <= {{PAD{1'b0}}, nextI};
            dut_b <= {{PAD{1'b0}}, nextJ};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_logic_op_bist.sv
// tb/tb_logic_op_bist.sv - directed bench for logic_op_bist
// Small instance (OP_BITS=2) for detailed checks, mid instance (OP_BITS=7) for a long sweep.
module tb_logic_op_bist;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        startS;
  logic [1:0]  opS;
  logic [31:0] aS, bS, xS;
  logic        busyS, doneS, passS, badS, fvS;
  logic [4:0]  errS;
  logic [1:0]  faS, fbS;
  int          modelOpS;
  logic        stuckS;

  logic        startM;
  logic [1:0]  opM;
  logic [31:0] aM, bM, xM;
  logic        busyM, doneM, passM, badM, fvM;
  logic [14:0] errM;
  logic [6:0]  faM, fbM;

  logic_op_bist #(.WIDTH(32), .OP_BITS(2)) uSmall (
    .clk(clk), .reset_n(reset_n), .start(startS), .op_sel(opS),
    .dut_a(aS), .dut_b(bS), .dut_x(xS), .busy(busyS), .done(doneS),
    .pass(passS), .bad_op(badS), .err_count(errS), .fail_valid(fvS),
    .fail_a(faS), .fail_b(fbS)
  );

  logic_op_bist #(.WIDTH(32), .OP_BITS(7)) uMid (
    .clk(clk), .reset_n(reset_n), .start(startM), .op_sel(opM),
    .dut_a(aM), .dut_b(bM), .dut_x(xM), .busy(busyM), .done(doneM),
    .pass(passM), .bad_op(badM), .err_count(errM), .fail_valid(fvM),
    .fail_a(faM), .fail_b(fbM)
  );

  always_comb begin
    case (modelOpS)
      0:       xS = aS ^ bS;
      1:       xS = aS & bS;
      default: xS = aS | bS;
    endcase
    if (stuckS) xS[0] = 1'b0;
  end

  assign xM = aM & bM;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a sweep at edge 0 and observes cycles 1..window at the falling edge.
  task automatic runSweep(input int which, input logic [1:0] op, input int restartAt,
                          input int resetAt, input int window, output int firstDone,
                          output int doneCount, output int busySeen, output logic passAtDone);
    logic d, b, pa;
    firstDone  = -1;
    doneCount  = 0;
    busySeen   = 0;
    passAtDone = 1'b0;
    @(negedge clk);
    if (which == 0) begin opS = op; startS = 1'b1; end
    else begin opM = op; startM = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    startS = 1'b0;
    startM = 1'b0;
    for (int c = 1; c <= window; c++) begin
      d  = (which == 0) ? doneS : doneM;
      b  = (which == 0) ? busyS : busyM;
      pa = (which == 0) ? passS : passM;
      if (d) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
        passAtDone = pa;
      end
      if (b) busySeen++;
      if (which == 0 && resetAt == 0 && op != 2'b11 && c <= 31 && (c % 2) == 1)
        checkVal($sformatf("pair_c%0d", c), {aS, bS},
                 {32'((c - 1) / 2 / 4), 32'(((c - 1) / 2) % 4)});
      if (resetAt > 0 && c == resetAt + 1) checkVal("busy_after_reset", 64'(b), 64'd0);
      if (which == 0) startS = (c == restartAt);
      else startM = (c == restartAt);
      reset_n = (c != resetAt);
      @(negedge clk);
    end
    reset_n = 1'b1;
    startS  = 1'b0;
    startM  = 1'b0;
  endtask

  int   fd, dc, bsy;
  logic pad;

  initial begin
    modelOpS = 0;
    stuckS   = 1'b0;
    opS      = 2'b00;
    opM      = 2'b01;
    reset_n  = 1'b0;
    startS   = 1'b1;
    startM   = 1'b1;

    // 1: reset with start held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_busy", 64'(busyS), 64'd0);
    checkVal("rst_done", 64'(doneS), 64'd0);
    checkVal("rst_pass", 64'(passS), 64'd0);
    checkVal("rst_err", 64'(errS), 64'd0);
    checkVal("rst_ab", {aS, bS}, 64'd0);
    startS  = 1'b0;
    startM  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checkVal("rst_idle_busy", 64'(busyS), 64'd0);

    // 2: correct XOR
    modelOpS = 0;
    runSweep(0, 2'b00, 0, 0, 40, fd, dc, bsy, pad);
    checkVal("xor_done_cycle", 64'(fd), 64'd33);
    checkVal("xor_done_count", 64'(dc), 64'd1);
    checkVal("xor_busy_cycles", 64'(bsy), 64'd32);
    checkVal("xor_pass_at_done", 64'(pad), 64'd1);
    checkVal("xor_err", 64'(errS), 64'd0);
    checkVal("xor_pass", 64'(passS), 64'd1);
    checkVal("xor_fv", 64'(fvS), 64'd0);

    // 3: XOR unit with bit0 stuck at 0
    stuckS = 1'b1;
    runSweep(0, 2'b00, 0, 0, 40, fd, dc, bsy, pad);
    stuckS = 1'b0;
    checkVal("stuck_done_cycle", 64'(fd), 64'd33);
    checkVal("stuck_err", 64'(errS), 64'd8);
    checkVal("stuck_fa", 64'(faS), 64'd0);
    checkVal("stuck_fb", 64'(fbS), 64'd1);
    checkVal("stuck_fv", 64'(fvS), 64'd1);
    checkVal("stuck_pass", 64'(passS), 64'd0);

    // 4: illegal op, then a correct OR sweep
    runSweep(0, 2'b11, 0, 0, 6, fd, dc, bsy, pad);
    checkVal("bad_done_cycle", 64'(fd), 64'd1);
    checkVal("bad_done_count", 64'(dc), 64'd1);
    checkVal("bad_busy", 64'(bsy), 64'd0);
    checkVal("bad_flag", 64'(badS), 64'd1);
    checkVal("bad_pass", 64'(passS), 64'd0);
    checkVal("bad_err", 64'(errS), 64'd0);
    modelOpS = 2;
    runSweep(0, 2'b10, 0, 0, 40, fd, dc, bsy, pad);
    checkVal("or_done_cycle", 64'(fd), 64'd33);
    checkVal("or_bad", 64'(badS), 64'd0);
    checkVal("or_pass", 64'(passS), 64'd1);

    // 5: correct AND, start mid-sweep ignored; then reset mid-sweep
    modelOpS = 1;
    runSweep(0, 2'b01, 10, 0, 40, fd, dc, bsy, pad);
    checkVal("and_restart_done_cycle", 64'(fd), 64'd33);
    checkVal("and_restart_done_count", 64'(dc), 64'd1);
    checkVal("and_pass", 64'(passS), 64'd1);
    runSweep(0, 2'b01, 0, 20, 40, fd, dc, bsy, pad);
    checkVal("and_reset_done_count", 64'(dc), 64'd0);
    checkVal("and_reset_busy", 64'(busyS), 64'd0);
    checkVal("and_reset_err", 64'(errS), 64'd0);
    checkVal("and_reset_pass", 64'(passS), 64'd0);

    // 6: long AND sweep on the wider instance: 2*128*128+1
    runSweep(1, 2'b01, 0, 0, 32775, fd, dc, bsy, pad);
    checkVal("mid_done_cycle", 64'(fd), 64'd32769);
    checkVal("mid_done_count", 64'(dc), 64'd1);
    checkVal("mid_pass", 64'(passM), 64'd1);
    checkVal("mid_err", 64'(errM), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
